// File: rtl/wb_periph_decoder.sv
// Single-master Wishbone classic address decoder and response tracker.
// Latency: slave strobe one cycle after the request; master ack/err one cycle after the slave ack or timeout.
// Backpressure: one transaction in flight; master inputs are ignored outside IDLE, except that dropping cyc aborts.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   wbm_*              master side (request in, registered ack/err/rdata out)
//   wbs_*              slave side (shared addr/wdata/we/sel, one-hot stb/cyc, per-slave ack/rdata)
//   err_count_o        saturating count of error responses returned to the master
module wb_periph_decoder #(
    parameter int                   ADDR_WIDTH     = 32,
    parameter int                   DATA_WIDTH     = 32,
    parameter int                   NUM_SLAVES     = 4,
    parameter int                   SEL_LSB        = 16,
    parameter int                   SEL_WIDTH      = 4,
    parameter int                   TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA      = 32'hDEAD_BEEF
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [ADDR_WIDTH-1:0]            wbm_addr_i,
    input  logic [DATA_WIDTH-1:0]            wbm_wdata_i,
    input  logic                             wbm_we_i,
    input  logic [DATA_WIDTH/8-1:0]          wbm_sel_i,
    input  logic                             wbm_stb_i,
    input  logic                             wbm_cyc_i,
    output logic [DATA_WIDTH-1:0]            wbm_rdata_o,
    output logic                             wbm_ack_o,
    output logic                             wbm_err_o,
    output logic [ADDR_WIDTH-1:0]            wbs_addr_o,
    output logic [DATA_WIDTH-1:0]            wbs_wdata_o,
    output logic                             wbs_we_o,
    output logic [DATA_WIDTH/8-1:0]          wbs_sel_o,
    output logic [NUM_SLAVES-1:0]            wbs_stb_o,
    output logic [NUM_SLAVES-1:0]            wbs_cyc_o,
    input  logic [NUM_SLAVES-1:0]            wbs_ack_i,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_rdata_i,
    output logic [7:0]                       err_count_o
);

    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [SEL_WIDTH-1:0]    idx_q, idx_d;
    logic [7:0]              tmo_q, tmo_d;
    logic [NUM_SLAVES-1:0]   stb_q, stb_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic [SW-1:0]           sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic [7:0]              cnt_q, cnt_d;

    logic [SEL_WIDTH-1:0]    req_idx;
    logic [31:0]             req_idx_ext;
    logic                    req_mapped;
    logic [NUM_SLAVES-1:0]   req_onehot;
    logic                    sel_ack;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic [7:0]              cnt_inc;

    assign req_idx     = wbm_addr_i[SEL_LSB +: SEL_WIDTH];
    assign req_idx_ext = {{(32-SEL_WIDTH){1'b0}}, req_idx};
    assign req_mapped  = (req_idx_ext < 32'(NUM_SLAVES));
    assign cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // Decode the request index and mux the selected slave's response.
    // Looping instead of indexing keeps unmapped indices from reading past the bus.
    always_comb begin
        req_onehot = '0;
        sel_ack    = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            req_onehot[i] = (req_idx == SEL_WIDTH'(i));
            if (idx_q == SEL_WIDTH'(i)) begin
                sel_ack   = wbs_ack_i[i];
                sel_rdata = wbs_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and next-output logic; every output is a flop fed from here.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        stb_d   = stb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    addr_d  = wbm_addr_i;
                    wdata_d = wbm_wdata_i;
                    we_d    = wbm_we_i;
                    sel_d   = wbm_sel_i;
                    idx_d   = req_idx;
                    tmo_d   = 8'd0;
                    if (req_mapped) begin
                        stb_d   = req_onehot;
                        state_d = ACCESS;
                    end else begin
                        // Unmapped: the error is raised straight away so it is visible in the RESP cycle.
                        err_d   = 1'b1;
                        rdata_d = ERR_DATA;
                        cnt_d   = cnt_inc;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                if (!wbm_cyc_i) begin
                    // Master abort: release the slave, no response.
                    stb_d   = '0;
                    state_d = IDLE;
                end else if (sel_ack) begin
                    stb_d   = '0;
                    ack_d   = 1'b1;
                    rdata_d = we_q ? '0 : sel_rdata;
                    state_d = RESP;
                end else if (tmo_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    stb_d   = '0;
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA;
                    cnt_d   = cnt_inc;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                stb_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tmo_q   <= '0;
            stb_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            stb_q   <= stb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Classic Wishbone slaves here see cyc and stb together, so one register drives both.
    assign wbs_stb_o   = stb_q;
    assign wbs_cyc_o   = stb_q;
    assign wbs_addr_o  = addr_q;
    assign wbs_wdata_o = wdata_q;
    assign wbs_we_o    = we_q;
    assign wbs_sel_o   = sel_q;
    assign wbm_rdata_o = rdata_q;
    assign wbm_ack_o   = ack_q;
    assign wbm_err_o   = err_q;
    assign err_count_o = cnt_q;

endmodule

// File: doc/wb_periph_decoder.md
# wb_periph_decoder

Single-master Wishbone (classic) address decoder and response tracker for the SoC's external Wishbone master port, i.e. the `wb_*_o`/`wb_*_i` bus leaving the OBI-to-WB bridge. It routes each cycle to one of `NUM_SLAVES` peripheral slaves and registers the slave response back to the master. Unmapped addresses and slaves that never acknowledge are terminated with an error response. The master therefore never hangs.

## Interface
- `ADDR_WIDTH`, 32: Wishbone address width.
- `DATA_WIDTH`, 32: Wishbone data width.
- `NUM_SLAVES`, 4: number of peripheral slaves, 1..16.
- `SEL_LSB`, 16: LSB of the slave-index field in the address.
- `SEL_WIDTH`, 4: width of the slave-index field; the index is `addr[SEL_LSB+SEL_WIDTH-1:SEL_LSB]`.
- `TIMEOUT_CYCLES`, 255: number of ACCESS cycles without ack before error; 1..255.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on any error response.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `wbm_addr_i` in ADDR_WIDTH: master address.
- `wbm_wdata_i` in DATA_WIDTH: master write data.
- `wbm_we_i` in 1: master write enable.
- `wbm_sel_i` in DATA_WIDTH/8: master byte enables.
- `wbm_stb_i` in 1: master strobe.
- `wbm_cyc_i` in 1: master cycle.
- `wbm_rdata_o` out DATA_WIDTH: read data to master.
- `wbm_ack_o` out 1: one-cycle success acknowledge to master.
- `wbm_err_o` out 1: one-cycle error termination to master.
- `wbs_addr_o` out ADDR_WIDTH: address shared by all slaves.
- `wbs_wdata_o` out DATA_WIDTH: write data shared by all slaves.
- `wbs_we_o` out 1: write enable shared by all slaves.
- `wbs_sel_o` out DATA_WIDTH/8: byte enables shared by all slaves.
- `wbs_stb_o` out NUM_SLAVES: one-hot strobe, one bit per slave.
- `wbs_cyc_o` out NUM_SLAVES: one-hot cycle, one bit per slave.
- `wbs_ack_i` in NUM_SLAVES: acknowledge from each slave.
- `wbs_rdata_i` in NUM_SLAVES*DATA_WIDTH: flattened slave read data; slave i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `err_count_o` out 8: saturating count of error responses.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE:**
  - On `wbm_cyc_i & wbm_stb_i`, register addr, wdata, we and sel into the `wbs_*` shared outputs.
  - Register the slave index `idx`.
  - If `idx < NUM_SLAVES`, go to ACCESS and set `wbs_stb_o[idx]` and `wbs_cyc_o[idx]`.
  - Otherwise set the pending error flag and go to RESP.
- **ACCESS:**
  - A timeout counter (8 bit) is cleared on ACCESS entry and increments every ACCESS cycle.
  - When `wbs_ack_i[idx]` is high: capture `wbs_rdata_i[idx]` (reads only; writes capture 0), clear the strobes and go to RESP.
  - Else if the counter equals `TIMEOUT_CYCLES-1`: clear the strobes, set the pending error flag and go to RESP.
  - Ack and timeout in the same cycle: ack wins.
  - Acks from non-selected slaves are ignored.
  - If `wbm_cyc_i` drops (master abort): clear the strobes and go to IDLE with no master response.
- **RESP:**
  - Assert exactly one of `wbm_ack_o` or `wbm_err_o` for one cycle, then go to IDLE.
  - `wbm_rdata_o` is `ERR_DATA` on error, otherwise the captured data.
  - `wbm_rdata_o` holds its value until the next RESP.
  - On each error, `err_count_o` increments and saturates at 255.
- Only one transaction is outstanding at a time. `wbm_*` inputs are ignored outside IDLE.

## Timing
- All outputs are registered.
- Reset values:
  - `wbs_stb_o`, `wbs_cyc_o`, `wbm_ack_o`, `wbm_err_o`: 0.
  - `wbm_rdata_o`, `wbs_addr_o`, `wbs_wdata_o`, `wbs_we_o`, `wbs_sel_o`: 0.
  - `err_count_o`: 0.
- Reset asserted mid-transaction clears everything immediately (asynchronous). The slave strobe drops with no master response.
- Request sampled at edge 0 (IDLE): slave strobe is high in cycle 1.
- Slave ack in cycle k (k ≥ 1): master ack in cycle k+1. Minimum latency is therefore 2 cycles from request to master ack.
- Unmapped address: `wbm_err_o` in cycle 1.
- Timeout: strobe is high for exactly `TIMEOUT_CYCLES` cycles (cycles 1..T), then `wbm_err_o` in cycle T+1.
- The master must deassert `wbm_stb_i` after seeing ack/err. A new request presented in the IDLE cycle after RESP is accepted, giving a 3-cycle minimum period.

## Test plan
- **Mapped read:** read addr 0x0001_0004 (idx 1); slave 1 acks in its first strobe cycle with 0x1234_5678.
  - `wbs_stb_o` = 4'b0010 in cycle 1.
  - `wbm_ack_o` high in cycle 2 with `wbm_rdata_o` = 0x1234_5678; `wbm_err_o` stays 0.
- **Write with wait states:** write 0xA5A5_A5A5, sel 4'b0011, to idx 3; slave acks after 5 strobe cycles.
  - `wbs_wdata_o`, `wbs_sel_o` and `wbs_we_o` are stable throughout.
  - Exactly one `wbm_ack_o` pulse, one cycle after the slave ack.
- **Unmapped and saturation:** with `NUM_SLAVES`=4, access idx 7.
  - No `wbs_stb_o` bit rises; `wbm_err_o` in cycle 1; `wbm_rdata_o` = 0xDEAD_BEEF; `err_count_o` = 1.
  - After 300 repetitions, `err_count_o` = 255.
- **Timeout:** with `TIMEOUT_CYCLES`=8, slave 0 never acks.
  - Strobe high for exactly 8 cycles, then `wbm_err_o`.
  - A second run where the ack arrives in the 8th strobe cycle returns `wbm_ack_o`, not err.
- **Abort and reset:** drop `wbm_cyc_i` in ACCESS cycle 3 → strobes clear next cycle, no ack/err, FSM in IDLE.
  - Repeat with `rst_ni` pulsed low mid-ACCESS instead → all outputs 0 immediately, and a following access completes normally.
- **Back-to-back:** two reads to idx 0 and idx 2, the second presented in the IDLE cycle right after the first ack.
  - Both complete with the correct data; ack pulses are 3 cycles apart.
  - Strobes are never simultaneously high on two slaves.
